// File: rtl/ads1115_scan_scheduler_if.sv
// Command/response bundle between the ADS1115 scan scheduler (master) and the I2C engine (slave).
// The engine pulses done once per strobed command; nack and rdata are only meaningful with done.
interface ads1115_scan_scheduler_if;
  logic        i2c_start;
  logic        i2c_rw;
  logic [6:0]  i2c_addr;
  logic [7:0]  i2c_reg;
  logic [15:0] i2c_wdata;
  logic        i2c_only_reg;
  logic        i2c_done;
  logic        i2c_nack;
  logic [15:0] i2c_rdata;

  modport master (
    output i2c_start, i2c_rw, i2c_addr, i2c_reg, i2c_wdata, i2c_only_reg,
    input  i2c_done, i2c_nack, i2c_rdata
  );

  modport slave (
    input  i2c_start, i2c_rw, i2c_addr, i2c_reg, i2c_wdata, i2c_only_reg,
    output i2c_done, i2c_nack, i2c_rdata
  );
endinterface

// File: rtl/ads1115_scan_scheduler.sv
// Sweeps enabled ADS1115 inputs: config write, conversion wait, pointer write, word read per channel.
// Define ADS_SCAN_LEVEL_EN to build the per-channel level comparators; otherwise level reads 0.
module ads1115_scan_scheduler #(
  parameter logic [6:0] ADS_ADDR         = 7'h48,
  parameter int         CONV_WAIT_CYCLES = 400000,
  parameter int         ENG_TIMEOUT      = 65535
`ifdef ADS_SCAN_LEVEL_EN
  ,
  parameter logic [15:0] LOW_TH   = 16'h0FA0,
  parameter logic [15:0] HIGH_TH  = 16'h59D8,
  parameter logic [15:0] FAULT_TH = 16'h7D00
`endif
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            scan_en,
  input  logic [3:0]                      ch_mask,
  ads1115_scan_scheduler_if.master        bus,
  output logic [63:0]                     result,
  output logic [3:0]                      result_valid,
  output logic [1:0]                      cur_ch,
  output logic                            busy,
  output logic                            sweep_done,
  output logic [7:0]                      err_cnt,
  output logic [7:0]                      level
);

  typedef enum logic [3:0] {IDLE, CFG, CFG_W, CONV, PTR, PTR_W, RD, RD_W, NEXT} state_t;

  state_t      state, state_nxt;
  logic [31:0] timer;
  logic [3:0]  mask_q;
  logic [1:0]  next_ch;
  logic        has_next;
  logic        in_wait, timer_hit, cmd_ok, abort, rd_ok, start_sweep;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (m[i]) r = 2'(i);
    return r;
  endfunction

  always_comb begin
    has_next = 1'b0;
    next_ch  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(cur_ch))) begin
        has_next = 1'b1;
        next_ch  = 2'(i);
      end
    end
  end

  assign in_wait   = state inside {CFG_W, PTR_W, RD_W};
  assign timer_hit = (state == CONV) ? (timer == 32'(CONV_WAIT_CYCLES - 1))
                                     : (timer == 32'(ENG_TIMEOUT - 1));
  // A done pulse takes priority over a timeout landing in the same cycle.
  assign cmd_ok    = in_wait && bus.i2c_done && !bus.i2c_nack;
  assign abort     = in_wait && ((bus.i2c_done && bus.i2c_nack) || (!bus.i2c_done && timer_hit));
  assign rd_ok     = cmd_ok && (state == RD_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (scan_en && ch_mask != 4'd0) state_nxt = CFG;
      CFG:   state_nxt = CFG_W;
      CFG_W: if (cmd_ok) state_nxt = CONV; else if (abort) state_nxt = NEXT;
      CONV:  if (timer_hit) state_nxt = PTR;
      PTR:   state_nxt = PTR_W;
      PTR_W: if (cmd_ok) state_nxt = RD; else if (abort) state_nxt = NEXT;
      RD:    state_nxt = RD_W;
      RD_W:  if (cmd_ok || abort) state_nxt = NEXT;
      NEXT: begin
        if (!scan_en)                 state_nxt = IDLE;
        else if (has_next)            state_nxt = CFG;
        else if (ch_mask != 4'd0)     state_nxt = CFG;
        else                          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.i2c_start    = state inside {CFG, PTR, RD};
    bus.i2c_rw       = state inside {RD, RD_W};
    bus.i2c_only_reg = state inside {PTR, PTR_W};
    bus.i2c_addr     = (state inside {CFG, CFG_W, PTR, PTR_W, RD, RD_W}) ? ADS_ADDR : 7'h00;
    bus.i2c_reg      = (state inside {CFG, CFG_W}) ? 8'h01 : 8'h00;
    bus.i2c_wdata    = (state inside {CFG, CFG_W}) ? {2'b11, cur_ch, 12'h383} : 16'h0000;
    busy             = (state != IDLE);
    sweep_done       = (state == NEXT) && (!scan_en || !has_next);
  end

  // New sweep: either from IDLE or wrapping around at the end of a sweep with scan_en still high.
  assign start_sweep = ((state == IDLE) || (state == NEXT && !has_next)) && (state_nxt == CFG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer        <= 32'd0;
      mask_q       <= 4'd0;
      cur_ch       <= 2'd0;
      err_cnt      <= 8'd0;
      result       <= 64'd0;
      result_valid <= 4'd0;
    end else begin
      timer        <= (state_nxt != state || state == IDLE) ? 32'd0 : timer + 32'd1;
      result_valid <= 4'd0;
      if (start_sweep) begin
        mask_q <= ch_mask;
        cur_ch <= lowest_set(ch_mask);
      end else if (state == NEXT && state_nxt == CFG) begin
        cur_ch <= next_ch;
      end
      if (abort && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (rd_ok) begin
        result[{cur_ch, 4'b0000} +: 16] <= bus.i2c_rdata;
        result_valid[cur_ch]            <= 1'b1;
      end
    end
  end

`ifdef ADS_SCAN_LEVEL_EN
  logic [1:0] lvl_code;

  always_comb begin
    if (bus.i2c_rdata < LOW_TH || bus.i2c_rdata > FAULT_TH) lvl_code = 2'b00;
    else if (bus.i2c_rdata > HIGH_TH)                       lvl_code = 2'b10;
    else                                                    lvl_code = 2'b01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        level <= 8'h00;
    else if (rd_ok) level[{cur_ch, 1'b0} +: 2] <= lvl_code;
  end
`else
  assign level = 8'h00;
`endif

endmodule

// File: tb/tb_ads1115_scan_scheduler.sv
// Directed bench for ads1115_scan_scheduler with an engine model that answers 5 cycles after a strobe.
module tb_ads1115_scan_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_en = 1'b0;
  logic [3:0]  ch_mask = 4'd0;
  logic [63:0] result;
  logic [3:0]  result_valid;
  logic [1:0]  cur_ch;
  logic        busy, sweep_done;
  logic [7:0]  err_cnt, level;

`ifdef ADS_SCAN_LEVEL_EN
  localparam logic [7:0] LVL_EXP = 8'b00_10_00_01;
`else
  localparam logic [7:0] LVL_EXP = 8'h00;
`endif

  ads1115_scan_scheduler_if bus();

  ads1115_scan_scheduler #(.CONV_WAIT_CYCLES(20), .ENG_TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .ch_mask(ch_mask), .bus(bus),
    .result(result), .result_valid(result_valid), .cur_ch(cur_ch), .busy(busy),
    .sweep_done(sweep_done), .err_cnt(err_cnt), .level(level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Engine model and activity log, both sampled on the falling edge.
  int          bfm_cnt = 0;
  logic [7:0]  cap_reg;
  logic        cap_rw, cap_only;
  logic [1:0]  cap_ch;
  int          nack_cfg_ch = -1;
  int          drop_ptr_ch = -1;
  logic [15:0] rd_tab [4];

  int          cyc = 0;
  int          busy_cnt, sd_cnt;
  logic [3:0]  rv_or;
  logic [3:0]  rv_q[$];
  int          q_cyc[$];
  logic [15:0] q_wd[$];
  logic [7:0]  q_reg[$];
  logic        q_rw[$], q_only[$];
  logic [1:0]  q_ch[$];
  logic [6:0]  q_addr[$];

  initial begin
    bus.i2c_done  = 1'b0;
    bus.i2c_nack  = 1'b0;
    bus.i2c_rdata = 16'h0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.i2c_done  = 1'b0;
      bus.i2c_nack  = 1'b0;
      bus.i2c_rdata = 16'h0;
      if (rst) begin
        bfm_cnt = 0;
      end else begin
        if (bfm_cnt > 0) begin
          bfm_cnt--;
          if (bfm_cnt == 0) begin
            bus.i2c_done  = 1'b1;
            bus.i2c_nack  = (cap_reg == 8'h01) && !cap_rw && (int'(cap_ch) == nack_cfg_ch);
            bus.i2c_rdata = cap_rw ? rd_tab[cap_ch] : 16'h0;
          end
        end
        if (bus.i2c_start) begin
          cap_reg  = bus.i2c_reg;
          cap_rw   = bus.i2c_rw;
          cap_only = bus.i2c_only_reg;
          cap_ch   = cur_ch;
          bfm_cnt  = (cap_only && int'(cap_ch) == drop_ptr_ch) ? 0 : 5;
        end
      end
      if (busy) busy_cnt++;
      if (sweep_done) sd_cnt++;
      if (result_valid != 4'd0) begin
        rv_q.push_back(result_valid);
        rv_or = rv_or | result_valid;
      end
      if (bus.i2c_start) begin
        q_cyc.push_back(cyc);
        q_wd.push_back(bus.i2c_wdata);
        q_reg.push_back(bus.i2c_reg);
        q_rw.push_back(bus.i2c_rw);
        q_only.push_back(bus.i2c_only_reg);
        q_ch.push_back(cur_ch);
        q_addr.push_back(bus.i2c_addr);
      end
    end
  end

  task automatic clear_logs();
    busy_cnt = 0; sd_cnt = 0; rv_or = 4'd0;
    rv_q.delete(); q_cyc.delete(); q_wd.delete(); q_reg.delete();
    q_rw.delete(); q_only.delete(); q_ch.delete(); q_addr.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; scan_en = 1'b0; ch_mask = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  // Wait for a strobe; with any=0 it must also match register, direction and channel.
  task automatic wait_cmd(input logic any, input logic [7:0] rg, input logic rw,
                          input logic [1:0] ch, input int budget, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.i2c_start && (any || (bus.i2c_reg == rg && bus.i2c_rw == rw && cur_ch == ch))) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, found, 1'b1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(tag, busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state, sampled while rst is held high.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_start", bus.i2c_start, 1'b0);
    check("rst_addr", bus.i2c_addr, 7'h00);
    check("rst_result", result, 64'd0);
    check("rst_misc", {err_cnt, level, result_valid, cur_ch, sweep_done}, 23'd0);

    // Two-channel sweep, ch0 and ch2.
    do_reset();
    rd_tab = '{16'h1234, 16'h0000, 16'h6000, 16'h0000};
    ch_mask = 4'b0101; scan_en = 1'b1;
    wait_cmd(1'b0, 8'h01, 1'b0, 2'd2, 500, "t1_ch2_cfg");
    scan_en = 1'b0;
    wait_idle(500, "t1_idle");
    check("t1_nstart", q_cyc.size(), 6);
    check("t1_wd_ch0", q_wd[0], 16'hC383);
    check("t1_cfg_reg", {q_reg[0], q_only[0], q_rw[0]}, {8'h01, 1'b0, 1'b0});
    check("t1_addr", q_addr[0], 7'h48);
    check("t1_ptr_cmd", {q_reg[1], q_only[1], q_rw[1]}, {8'h00, 1'b1, 1'b0});
    check("t1_rd_cmd", {q_reg[2], q_only[2], q_rw[2]}, {8'h00, 1'b0, 1'b1});
    check("t1_conv_gap", q_cyc[1] - q_cyc[0], 26);
    check("t1_wd_ch2", q_wd[3], 16'hE383);
    check("t1_res0", result[15:0], 16'h1234);
    check("t1_res2", result[47:32], 16'h6000);
    check("t1_res13", {result[63:48], result[31:16]}, 32'd0);
    check("t1_rv_n", rv_q.size(), 2);
    check("t1_rv0", rv_q[0], 4'b0001);
    check("t1_rv1", rv_q[1], 4'b0100);
    check("t1_sweeps", sd_cnt, 1);
    check("t1_err", err_cnt, 8'd0);
    check("t1_level", level, LVL_EXP);

    // NACK on ch1 config write.
    do_reset();
    rd_tab = '{16'h1111, 16'h2222, 16'h3333, 16'h0000};
    nack_cfg_ch = 1;
    ch_mask = 4'b0111; scan_en = 1'b1;
    wait_cmd(1'b0, 8'h01, 1'b0, 2'd2, 500, "t2_ch2_cfg");
    scan_en = 1'b0;
    wait_idle(500, "t2_idle");
    nack_cfg_ch = -1;
    check("t2_err", err_cnt, 8'd1);
    check("t2_rv_or", rv_or, 4'b0101);
    check("t2_res1", result[31:16], 16'h0000);
    check("t2_res2", result[47:32], 16'h3333);
    check("t2_nstart", q_cyc.size(), 7);
    check("t2_next_wd", q_wd[4], 16'hE383);
    check("t2_skip_gap", q_cyc[4] - q_cyc[3], 7);

    // Engine never answers the ch0 pointer write.
    do_reset();
    drop_ptr_ch = 0;
    ch_mask = 4'b0011; scan_en = 1'b1;
    wait_cmd(1'b0, 8'h01, 1'b0, 2'd1, 800, "t3_ch1_cfg");
    scan_en = 1'b0;
    wait_idle(500, "t3_idle");
    drop_ptr_ch = -1;
    check("t3_timeout_gap", q_cyc[2] - q_cyc[1], 102);
    check("t3_next_wd", q_wd[2], 16'hD383);
    check("t3_err", err_cnt, 8'd1);
    check("t3_rv_or", rv_or, 4'b0010);
    check("t3_res0", result[15:0], 16'h0000);

    // scan_en dropped during ch1 conversion wait.
    do_reset();
    ch_mask = 4'b1111; scan_en = 1'b1;
    wait_cmd(1'b0, 8'h01, 1'b0, 2'd1, 500, "t4_ch1_cfg");
    repeat (10) @(negedge clk);
    scan_en = 1'b0;
    wait_idle(500, "t4_idle");
    n = 0;
    foreach (q_ch[i]) if (q_ch[i] >= 2'd2) n++;
    check("t4_no_ch2", n, 0);
    check("t4_nstart", q_cyc.size(), 6);
    check("t4_rv_or", rv_or, 4'b0011);
    check("t4_sweeps", sd_cnt, 1);

    // Asynchronous reset while a read is outstanding.
    do_reset();
    ch_mask = 4'b0110; scan_en = 1'b1;
    wait_cmd(1'b0, 8'h00, 1'b1, 2'd1, 500, "t5_rd_ch1");
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_busy", busy, 1'b0);
    check("t5_rw", bus.i2c_rw, 1'b0);
    check("t5_addr", bus.i2c_addr, 7'h00);
    check("t5_cur_ch", cur_ch, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    wait_cmd(1'b1, 8'h00, 1'b0, 2'd0, 50, "t5_restart");
    check("t5_first_ch", cur_ch, 2'd1);
    check("t5_first_wd", bus.i2c_wdata, 16'hD383);
    scan_en = 1'b0;
    wait_idle(500, "t5_idle");

    // Empty mask: nothing may start.
    do_reset();
    ch_mask = 4'b0000; scan_en = 1'b1;
    repeat (1000) @(negedge clk);
    check("t6_nstart", q_cyc.size(), 0);
    check("t6_busy_cycles", busy_cnt, 0);
    scan_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
